// File: rtl/ncc_window_ctrl.sv
// rtl/ncc_window_ctrl.sv - row-BRAM window loader and column scanner for NCC (optional abort: NCC_WIN_ABORT_EN)
module ncc_window_ctrl #(
   parameter int ROWS = 16,
   parameter int COLS = 80,
   parameter int AW   = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_start,
   input  logic [7:0]      pix_in,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic [ROWS-1:0] win_wr,
   output logic [AW-1:0]   win_addr,
   output logic [7:0]      win_din,
   output logic            win_rd,
   input  logic            scan_start,
   output logic            col_valid,
   output logic [AW-1:0]   col_idx,
   output logic            load_done,
   output logic            scan_done,
   output logic            busy
`ifdef NCC_WIN_ABORT_EN
   ,
   input  logic            abort
`endif
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [AW-1:0] COL_LAST = AW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOADED,
      S_SCAN,
      S_DRAIN
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [RW-1:0]   r_row;
   logic [RW-1:0]   w_row_nxt;
   logic [AW-1:0]   r_col;
   logic [AW-1:0]   w_col_nxt;
   logic            r_load_done;
   logic            w_load_done_nxt;
   logic            r_scan_done;
   logic            w_scan_done_nxt;
   logic            r_col_valid;
   logic [AW-1:0]   r_col_idx;
   logic            w_abort;
   logic            w_accept;

`ifdef NCC_WIN_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Next-state, counter updates and combinational BRAM/handshake outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_load_done_nxt = r_load_done;
      w_scan_done_nxt = 1'b0;
      w_accept        = 1'b0;
      pix_ready       = 1'b0;
      win_wr          = '0;
      win_addr        = '0;
      win_din         = '0;
      win_rd          = 1'b0;
      busy            = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (load_start) begin
               w_state_nxt     = S_LOAD;
               w_row_nxt       = '0;
               w_col_nxt       = '0;
               w_load_done_nxt = 1'b0;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            pix_ready = 1'b1;
            win_addr  = r_col;
            w_accept  = pix_valid && !w_abort;
            if (w_accept) begin
               win_wr  = ROWS'(1) << r_row;
               win_din = pix_in;
               if (r_col == COL_LAST) begin
                  w_col_nxt = '0;
                  if (r_row == ROW_LAST) begin
                     w_row_nxt       = '0;
                     w_state_nxt     = S_LOADED;
                     w_load_done_nxt = 1'b1;
                  end else begin
                     w_row_nxt = r_row + 1'b1;
                  end
               end else begin
                  w_col_nxt = r_col + 1'b1;
               end
            end
         end
         S_LOADED: begin
            // A reload request takes priority over a scan request
            if (load_start) begin
               w_state_nxt     = S_LOAD;
               w_row_nxt       = '0;
               w_col_nxt       = '0;
               w_load_done_nxt = 1'b0;
            end else if (scan_start) begin
               w_state_nxt = S_SCAN;
               w_col_nxt   = '0;
            end
         end
         S_SCAN: begin
            busy     = 1'b1;
            win_rd   = 1'b1;
            win_addr = r_col;
            if (r_col == COL_LAST) begin
               w_col_nxt   = '0;
               w_state_nxt = S_DRAIN;
            end else begin
               w_col_nxt = r_col + 1'b1;
            end
         end
         S_DRAIN: begin
            busy            = 1'b1;
            w_state_nxt     = S_LOADED;
            w_scan_done_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_abort) begin
         w_state_nxt     = S_IDLE;
         w_row_nxt       = '0;
         w_col_nxt       = '0;
         w_load_done_nxt = 1'b0;
         w_scan_done_nxt = 1'b0;
      end
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_load_done <= 1'b0;
         r_scan_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_load_done <= w_load_done_nxt;
         r_scan_done <= w_scan_done_nxt;
      end
   end

   // Column-valid tracks the one-cycle BRAM read latency; an abort kills the in-flight read
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_col_valid <= 1'b0;
         r_col_idx   <= '0;
      end else begin
         r_col_valid <= win_rd && !w_abort;
         r_col_idx   <= win_addr;
      end
   end

   assign col_valid = r_col_valid;
   assign col_idx   = r_col_idx;
   assign load_done = r_load_done;
   assign scan_done = r_scan_done;

endmodule

// File: tb/tb_ncc_window_ctrl.sv
// tb/tb_ncc_window_ctrl.sv - directed self-checking bench for ncc_window_ctrl
module tb_ncc_window_ctrl;

   localparam int ROWS = 16;
   localparam int COLS = 80;
   localparam int AW   = 10;
   localparam int NPIX = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_start = 1'b0;
   logic [7:0]      pix_in = 8'h00;
   logic            pix_valid = 1'b0;
   logic            scan_start = 1'b0;
   logic            pix_ready;
   logic [ROWS-1:0] win_wr;
   logic [AW-1:0]   win_addr;
   logic [7:0]      win_din;
   logic            win_rd;
   logic            col_valid;
   logic [AW-1:0]   col_idx;
   logic            load_done;
   logic            scan_done;
   logic            busy;
`ifdef NCC_WIN_ABORT_EN
   logic            abort = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   ncc_window_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_wr     (win_wr),
      .win_addr   (win_addr),
      .win_din    (win_din),
      .win_rd     (win_rd),
      .scan_start (scan_start),
      .col_valid  (col_valid),
      .col_idx    (col_idx),
      .load_done  (load_done),
      .scan_done  (scan_done),
      .busy       (busy)
`ifdef NCC_WIN_ABORT_EN
      ,
      .abort      (abort)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input bit start, input bit gaps, input string tag);
      int wcount = 0;
      int ord_err = 0;
      int idle_wr = 0;
      int cyc = 0;
      int er = 0;
      int ec = 0;
      logic [7:0] d;
      if (start) begin
         load_start = 1'b1;
         step();
         load_start = 1'b0;
      end
      while (wcount < NPIX && cyc < 5000) begin
         pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         d = 8'(wcount) ^ 8'hA5;
         pix_in = d;
         #1;
         if (pix_ready !== 1'b1) ord_err++;
         if (pix_valid) begin
            if (win_wr !== (ROWS'(1) << er) || win_addr !== AW'(ec) || win_din !== d) ord_err++;
            if (wcount == 0) begin
               check({tag, "_first_wr"}, 32'(win_wr), 32'h0001);
               check({tag, "_first_addr"}, 32'(win_addr), 32'd0);
            end
            if (wcount == 80) begin
               check({tag, "_wr80"}, 32'(win_wr), 32'h0002);
               check({tag, "_addr80"}, 32'(win_addr), 32'd0);
            end
            if (wcount == NPIX - 1) begin
               check({tag, "_last_wr"}, 32'(win_wr), 32'h8000);
               check({tag, "_last_addr"}, 32'(win_addr), 32'd79);
            end
            wcount++;
            ec++;
            if (ec == COLS) begin
               ec = 0;
               er++;
            end
         end else if (win_wr !== '0) begin
            idle_wr++;
         end
         step();
         cyc++;
      end
      pix_valid = 1'b0;
      check({tag, "_writes"}, wcount, NPIX);
      check({tag, "_order_err"}, ord_err, 0);
      check({tag, "_wr_no_valid"}, idle_wr, 0);
      check({tag, "_load_done"}, 32'(load_done), 32'd1);
      check({tag, "_ready_after"}, 32'(pix_ready), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      if (gaps) check({tag, "_gaps_seen"}, 32'(cyc > NPIX), 32'd1);
   endtask

   task automatic do_scan(input string tag);
      int rd_n = 0;
      int cv_n = 0;
      int sd_n = 0;
      int sd_cyc = -1;
      int rd_first = -1;
      int cv_first = -1;
      int cv_last = -1;
      int addr_err = 0;
      int idx_err = 0;
      int wr_err = 0;
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      for (int t = 0; t < 90; t++) begin
         #1;
         if (win_rd) begin
            if (rd_first < 0) rd_first = t;
            if (win_addr !== AW'(rd_n)) addr_err++;
            rd_n++;
         end
         if (col_valid) begin
            if (cv_first < 0) cv_first = t;
            cv_last = t;
            if (col_idx !== AW'(cv_n)) idx_err++;
            cv_n++;
         end
         if (scan_done) begin
            sd_n++;
            sd_cyc = t;
         end
         if (win_wr !== '0) wr_err++;
         step();
      end
      check({tag, "_rd_count"}, rd_n, 80);
      check({tag, "_rd_first"}, rd_first, 0);
      check({tag, "_rd_addr_err"}, addr_err, 0);
      check({tag, "_cv_count"}, cv_n, 80);
      check({tag, "_cv_first"}, cv_first, 1);
      check({tag, "_cv_last"}, cv_last, 80);
      check({tag, "_cv_idx_err"}, idx_err, 0);
      check({tag, "_done_pulses"}, sd_n, 1);
      check({tag, "_done_cycle"}, sd_cyc, 81);
      check({tag, "_no_wr"}, wr_err, 0);
      check({tag, "_still_loaded"}, 32'(load_done), 32'd1);
   endtask

   initial begin
      int wr;

      rst = 1'b0;
      repeat (3) step();
      check("rst_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_win_wr", 32'(win_wr), 32'd0);
      check("rst_win_addr", 32'(win_addr), 32'd0);
      check("rst_win_din", 32'(win_din), 32'd0);
      check("rst_win_rd", 32'(win_rd), 32'd0);
      check("rst_col_valid", 32'(col_valid), 32'd0);
      check("rst_col_idx", 32'(col_idx), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_scan_done", 32'(scan_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      step();

      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      #1;
      check("idle_scan_busy", 32'(busy), 32'd0);
      check("idle_scan_rd", 32'(win_rd), 32'd0);

      do_load(1'b1, 1'b0, "load0");
      do_scan("scan0");
      do_scan("scan1");

      load_start = 1'b1;
      scan_start = 1'b1;
      step();
      load_start = 1'b0;
      scan_start = 1'b0;
      #1;
      check("both_busy", 32'(busy), 32'd1);
      check("both_pix_ready", 32'(pix_ready), 32'd1);
      check("both_load_done", 32'(load_done), 32'd0);
      check("both_win_rd", 32'(win_rd), 32'd0);

      do_load(1'b0, 1'b1, "load_gap");
      do_scan("scan2");

      load_start = 1'b1;
      step();
      load_start = 1'b0;
      pix_valid = 1'b1;
      repeat (300) step();
      rst = 1'b0;
      repeat (3) step();
      check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
      check("mid_rst_win_wr", 32'(win_wr), 32'd0);
      check("mid_rst_win_addr", 32'(win_addr), 32'd0);
      check("mid_rst_win_din", 32'(win_din), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_load_done", 32'(load_done), 32'd0);
      rst = 1'b1;
      wr = 0;
      repeat (5) begin
         step();
         if (win_wr !== '0) wr++;
      end
      check("post_rst_no_wr", wr, 0);
      check("post_rst_busy", 32'(busy), 32'd0);
      pix_valid = 1'b0;

`ifdef NCC_WIN_ABORT_EN
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      pix_valid = 1'b1;
      repeat (500) step();
      abort = 1'b1;
      #1;
      check("abort_cycle_wr", 32'(win_wr), 32'd0);
      step();
      abort = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_pix_ready", 32'(pix_ready), 32'd0);
      check("abort_load_done", 32'(load_done), 32'd0);
      wr = 0;
      repeat (5) begin
         step();
         if (win_wr !== '0) wr++;
      end
      check("abort_no_wr", wr, 0);
      pix_valid = 1'b0;
      do_load(1'b1, 1'b0, "reload_after_abort");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
